// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg: record kinds, the packed 54-bit trace record, and the block's default parameters.
package commit_trace_pkg;
  localparam int DEFAULT_DEPTH       = 16;
  localparam int DEFAULT_CYCLE_LIMIT = 1000;
  typedef enum logic [1:0] {
    KIND_NOP  = 2'd0,
    KIND_REG  = 2'd1,
    KIND_MEM  = 2'd2,
    KIND_HALT = 2'd3
  } rec_kind_e;
  typedef struct packed {
    rec_kind_e   kind;
    logic [15:0] pc;
    logic [3:0]  rg;
    logic [15:0] data;
    logic [15:0] addr;
  } trace_rec_t;
  localparam int REC_W = $bits(trace_rec_t);
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: circular record store. Extra pointer bit tells full from empty; reads 0 when empty.
module trace_fifo #(
  parameter int WIDTH = 54,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o  = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: classifies each retiring instruction into a trace record and queues it for a consumer.
// Optional cycle watchdog is built only when TRACE_WATCHDOG_EN is defined.
module commit_trace_buffer
  import commit_trace_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int CYCLE_LIMIT = DEFAULT_CYCLE_LIMIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic        hlt,
  input  logic        reg_we,
  input  logic [3:0]  reg_dst,
  input  logic [15:0] reg_data,
  input  logic        mem_rd,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [1:0]  rec_kind,
  output logic [15:0] rec_pc,
  output logic [3:0]  rec_reg,
  output logic [15:0] rec_data,
  output logic [15:0] rec_addr,
  output logic [15:0] inst_count,
  output logic [15:0] cycle_count,
  output logic        halted,
  output logic        overflow,
  output logic        timeout
);
  trace_rec_t  rec_d, rec_out;
  logic        capture, push, pop, full, empty;
  logic        halted_q, overflow_q;
  logic [15:0] inst_count_q, inst_count_d, cycle_count_q, cycle_count_d;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CYCLE_LIMIT < 1)
    $error("commit_trace_buffer: DEPTH must be a power of two >= 2 and CYCLE_LIMIT >= 1");
  assign capture       = !halted_q && !timeout;
  assign pop           = rec_valid && rec_ready;
  assign push          = capture && (!full || pop);
  assign inst_count_d  = inst_count_q + {15'd0, capture && inst_count_q != 16'hFFFF};
  assign cycle_count_d = cycle_count_q + {15'd0, capture && cycle_count_q != 16'hFFFF};
  always_comb begin
    rec_d    = '0;
    rec_d.pc = pc;
    if (hlt) begin
      rec_d.kind = KIND_HALT;
    end else if (reg_we) begin
      rec_d.kind = KIND_REG;
      rec_d.rg   = reg_dst;
      rec_d.data = reg_data;
      rec_d.addr = mem_rd ? mem_addr : '0;
    end else if (mem_we) begin
      rec_d.kind = KIND_MEM;
      rec_d.data = mem_wdata;
      rec_d.addr = mem_addr;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q      <= 1'b0;
      overflow_q    <= 1'b0;
      inst_count_q  <= '0;
      cycle_count_q <= '0;
    end else begin
      halted_q      <= halted_q | (capture & hlt);
      overflow_q    <= overflow_q | (capture & full & ~pop);
      inst_count_q  <= inst_count_d;
      cycle_count_q <= cycle_count_d;
    end
  end
`ifdef TRACE_WATCHDOG_EN
  logic timeout_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timeout_q <= 1'b0;
    else        timeout_q <= timeout_q | (capture && cycle_count_d == 16'(CYCLE_LIMIT));
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif
  trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (rec_d),
    .rdata_o (rec_out),
    .full_o  (full),
    .empty_o (empty)
  );
  assign rec_valid   = !empty;
  assign rec_kind    = rec_out.kind;
  assign rec_pc      = rec_out.pc;
  assign rec_reg     = rec_out.rg;
  assign rec_data    = rec_out.data;
  assign rec_addr    = rec_out.addr;
  assign inst_count  = inst_count_q;
  assign cycle_count = cycle_count_q;
  assign halted      = halted_q;
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: randomized and directed stimulus, queue-based reference model, decoupled monitor.
module tb_commit_trace_buffer;
  localparam int DEPTH = 16;
  localparam int LIMIT = 1000;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] pc, reg_data, mem_addr, mem_wdata;
  logic        hlt, reg_we, mem_rd, mem_we, rec_ready;
  logic [3:0]  reg_dst;
  logic        rec_valid, halted, overflow, timeout;
  logic [1:0]  rec_kind;
  logic [15:0] rec_pc, rec_data, rec_addr, inst_count, cycle_count;
  logic [3:0]  rec_reg;

  commit_trace_buffer dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .hlt(hlt), .reg_we(reg_we), .reg_dst(reg_dst),
    .reg_data(reg_data), .mem_rd(mem_rd), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
    .rec_pc(rec_pc), .rec_reg(rec_reg), .rec_data(rec_data), .rec_addr(rec_addr),
    .inst_count(inst_count), .cycle_count(cycle_count), .halted(halted),
    .overflow(overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  logic [53:0] exp_q[$];
  logic [53:0] last_rec = '0;
  int          m_cnt = 0, m_inst = 0, m_cyc = 0;
  logic        m_halted = 1'b0, m_ovf = 1'b0, m_to = 1'b0;
  logic [15:0] s_pc, s_data, s_addr, s_wdata;
  logic [3:0]  s_dst;
  logic        s_hlt, s_we, s_rd, s_mwe, s_rdy;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [53:0] dut_rec();
    return {rec_kind, rec_pc, rec_reg, rec_data, rec_addr};
  endfunction

  // Monitor: mid-cycle, compare visible state with the model and retire popped records.
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", {63'd0, rec_valid}, {63'd0, m_cnt > 0});
      check("status", {inst_count, cycle_count, halted, overflow, timeout},
            {m_inst[15:0], m_cyc[15:0], m_halted, m_ovf, m_to});
      if (rec_valid && rec_ready) begin
        last_rec = dut_rec();
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL record: popped %h with nothing expected at %0t", last_rec, $time);
        end else begin
          check("record", last_rec, exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic [53:0] spec_rec();
    if (s_hlt)  return {2'd3, s_pc, 4'd0, 16'd0, 16'd0};
    if (s_we)   return {2'd1, s_pc, s_dst, s_data, s_rd ? s_addr : 16'd0};
    if (s_mwe)  return {2'd2, s_pc, 4'd0, s_wdata, s_addr};
    return {2'd0, s_pc, 36'd0};
  endfunction

  task automatic step();
    logic popn;
    int   n_cnt, n_inst, n_cyc;
    logic n_h, n_o, n_t;
    pc = s_pc; hlt = s_hlt; reg_we = s_we; reg_dst = s_dst; reg_data = s_data;
    mem_rd = s_rd; mem_we = s_mwe; mem_addr = s_addr; mem_wdata = s_wdata; rec_ready = s_rdy;
    popn   = m_cnt > 0 && s_rdy;
    n_cnt  = m_cnt - (popn ? 1 : 0);
    n_inst = m_inst; n_cyc = m_cyc; n_h = m_halted; n_o = m_ovf; n_t = m_to;
    if (!(m_halted || m_to)) begin
      n_inst = m_inst == 65535 ? m_inst : m_inst + 1;
      n_cyc  = m_cyc == 65535 ? m_cyc : m_cyc + 1;
      if (m_cnt < DEPTH || popn) begin
        exp_q.push_back(spec_rec());
        n_cnt++;
      end else begin
        n_o = 1'b1;
      end
      if (s_hlt) n_h = 1'b1;
`ifdef TRACE_WATCHDOG_EN
      if (n_cyc == LIMIT) n_t = 1'b1;
`endif
    end
    @(posedge clk);
    #1;
    m_cnt = n_cnt; m_inst = n_inst; m_cyc = n_cyc; m_halted = n_h; m_ovf = n_o; m_to = n_t;
  endtask

  task automatic set_s(input logic [15:0] p, input logic h, input logic we, input logic [3:0] dst,
                       input logic [15:0] d, input logic rd, input logic mwe,
                       input logic [15:0] a, input logic [15:0] wd, input logic rdy);
    s_pc = p; s_hlt = h; s_we = we; s_dst = dst; s_data = d;
    s_rd = rd; s_mwe = mwe; s_addr = a; s_wdata = wd; s_rdy = rdy;
  endtask

  task automatic rnd_stim(input bit allow_hlt, input int rdy_pct);
    set_s(16'($urandom), allow_hlt && $urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
          4'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
          16'($urandom), $urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_cnt = 0; m_inst = 0; m_cyc = 0; m_halted = 1'b0; m_ovf = 1'b0; m_to = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_s(16'd0, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    set_s(16'd0, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    pc = 0; hlt = 0; reg_we = 0; reg_dst = 0; reg_data = 0;
    mem_rd = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; rec_ready = 0;
    #12;
    check("reset_rec", {rec_valid, rec_kind, rec_pc, rec_reg, rec_data, rec_addr}, 64'd0);
    check("reset_status", {inst_count, cycle_count, halted, overflow, timeout}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    set_s(16'h0002, 1'b0, 1'b1, 4'd3, 16'h00A5, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
    step();
    check("reg_write", {rec_valid, rec_kind, rec_reg, rec_data, rec_pc},
          {1'b1, 2'd1, 4'd3, 16'h00A5, 16'h0002});
    set_s(16'h0004, 1'b0, 1'b1, 4'd5, 16'h1234, 1'b1, 1'b0, 16'h0040, 16'd0, 1'b1);
    step();
    check("load", {rec_valid, rec_kind, rec_reg, rec_addr}, {1'b1, 2'd1, 4'd5, 16'h0040});
    set_s(16'h0006, 1'b0, 1'b0, 4'd7, 16'd0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b1);
    step();
    check("store", {rec_valid, rec_kind, rec_reg, rec_addr, rec_data},
          {1'b1, 2'd2, 4'd0, 16'h0010, 16'hBEEF});

    do_reset();
    for (int i = 0; i < 20; i++) begin
      rnd_stim(1'b0, 0);
      step();
    end
    check("stall_overflow", {rec_valid, overflow, inst_count}, {1'b1, 1'b1, 16'd20});
    for (int i = 0; i < 20; i++) begin
      set_s(16'($urandom), 1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
      step();
    end

    do_reset();
    for (int i = 0; i < 6; i++) begin
      rnd_stim(1'b0, 60);
      step();
    end
    rnd_stim(1'b0, 60);
    s_pc  = 16'h000C;
    s_hlt = 1'b1;
    step();
    check("halt", {halted, inst_count}, {1'b1, 16'd7});
    for (int i = 0; i < 25; i++) begin
      rnd_stim(1'b1, 100);
      step();
    end
    check("halt_drained", {rec_valid, inst_count, 32'(exp_q.size())}, {1'b0, 16'd7, 32'd0});
    check("halt_last", {last_rec[53:52], last_rec[51:36]}, {2'd3, 16'h000C});

    do_reset();
    for (int i = 0; i < 400; i++) begin
      rnd_stim(1'b1, 70);
      step();
    end

    do_reset();
    for (int i = 0; i < 5; i++) begin
      rnd_stim(1'b0, 0);
      step();
    end
    check("pre_async_reset", {rec_valid, inst_count}, {1'b1, 16'd5});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {rec_valid, inst_count, cycle_count, rec_kind, rec_pc, rec_data}, 64'd0);
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < LIMIT + 10; i++) begin
      rnd_stim(1'b0, 100);
      step();
    end
`ifdef TRACE_WATCHDOG_EN
    check("watchdog", {timeout, cycle_count, inst_count}, {1'b1, 16'(LIMIT), 16'(LIMIT)});
`else
    check("watchdog", {timeout, cycle_count, inst_count}, {1'b0, 16'(LIMIT + 10), 16'(LIMIT + 10)});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
